// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: single-clock fetch/sequencing unit for the PIC core.
// Produces one-hot phase enables, the program counter, the instruction
// register with branch flush, and a circular call/return stack.
module pic_fetch_unit #(
    parameter int unsigned PC_WIDTH    = 12,
    parameter int unsigned INSTR_WIDTH = 14,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned NUM_PHASES  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   master_clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   jump_req,
    input  logic                   call_req,
    input  logic                   return_req,
    input  logic                   skip_req,
    input  logic [PC_WIDTH-1:0]    target,
    output logic [NUM_PHASES-1:0]  phase,
    output logic                   cycle_end,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    tos,
    output logic                   stack_overflow,
    output logic                   stack_underflow
);

    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;

    logic                cycle_edge;
    logic                do_ret;
    logic                do_call;
    logic                do_jump;
    logic                do_skip;
    logic [PTR_W-1:0]    ptr_up;
    logic [PTR_W-1:0]    ptr_down;
    logic [PTR_W-1:0]    ptr_down2;
    logic [PC_WIDTH-1:0] pc_next;
    logic                valid_next;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_PTR : p - PTR_W'(1);
    endfunction

    assign cycle_end = phase[NUM_PHASES-1];

    // Request decode with priority return > call > jump > skip, and next PC.
    always_comb begin
        cycle_edge = phase[NUM_PHASES-1] & ~stall;
        do_ret     = 1'b0;
        do_call    = 1'b0;
        do_jump    = 1'b0;
        do_skip    = 1'b0;
        ptr_up     = ptr_inc(wr_ptr);
        ptr_down   = ptr_dec(wr_ptr);
        ptr_down2  = ptr_dec(ptr_down);
        pc_next    = pc + PC_WIDTH'(1);
        valid_next = 1'b1;
        if (cycle_edge && instr_valid) begin
            if (return_req) begin
                do_ret = 1'b1;
            end else if (call_req) begin
                do_call = 1'b1;
            end else if (jump_req) begin
                do_jump = 1'b1;
            end else if (skip_req) begin
                do_skip = 1'b1;
            end
        end
        if (do_ret) begin
            pc_next = stack_mem[ptr_down];
        end else if (do_call || do_jump) begin
            pc_next = target;
        end
        if (do_ret || do_call || do_jump || do_skip) begin
            valid_next = 1'b0;
        end
    end

    // Phase ring, fetch registers and call stack; everything frozen by stall.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            phase           <= NUM_PHASES'(1);
            pc              <= RESET_VECTOR;
            instr           <= '0;
            instr_valid     <= 1'b0;
            wr_ptr          <= '0;
            count           <= '0;
            tos             <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (!stall) begin
            phase <= {phase[NUM_PHASES-2:0], phase[NUM_PHASES-1]};
            if (cycle_edge) begin
                instr       <= imem_data;
                pc          <= pc_next;
                instr_valid <= valid_next;
            end
            if (do_call) begin
                stack_mem[wr_ptr] <= pc;
                wr_ptr            <= ptr_up;
                tos               <= pc;
                if (count == FULL_CNT) begin
                    stack_overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_ret) begin
                wr_ptr <= ptr_down;
                tos    <= stack_mem[ptr_down2];
                if (count == '0) begin
                    stack_underflow <= 1'b1;
                end else begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule
